// File: rtl/conv8_32.sv
// Receive-side 8-to-32 packer: gathers qualified bytes into 32-bit words,
// pulses out32 per completed word and err8 when an idle partial word is dropped.
module conv8_32 #(
   parameter int MSB_FIRST = 1,
   parameter int GAP_MAX   = 8,
   parameter int GAP_W     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data8,
   input  logic        in8,
   output logic [31:0] out_data32,
   output logic        out32,
   output logic        err8,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, B1, B2, B3} cnt_t;

   cnt_t             cnt, cnt_nxt;
   logic [GAP_W-1:0] idle, idle_nxt;
   logic [GAP_W:0]   idle_inc;
   logic [31:0]      asm_r, asm_nxt, word_nxt, out_data_nxt;
   logic [1:0]       slot;
   logic             out32_nxt, err8_nxt, timeout;

   always_comb begin
      cnt_nxt      = cnt;
      idle_nxt     = idle;
      asm_nxt      = asm_r;
      out_data_nxt = out_data32;
      out32_nxt    = 1'b0;
      err8_nxt     = 1'b0;
      // 3-cnt equals the bitwise inverse of a 2-bit count
      slot         = (MSB_FIRST != 0) ? ~cnt : cnt;
      word_nxt     = asm_r;
      word_nxt[8*slot +: 8] = in_data8;
      idle_inc     = {1'b0, idle} + (GAP_W+1)'(1);
      timeout      = (GAP_MAX != 0) && (idle_inc == (GAP_W+1)'(GAP_MAX));

      if (in8) begin
         idle_nxt = '0;
         unique case (cnt)
            IDLE: begin
               cnt_nxt = B1;
               asm_nxt = word_nxt;
            end
            B1: begin
               cnt_nxt = B2;
               asm_nxt = word_nxt;
            end
            B2: begin
               cnt_nxt = B3;
               asm_nxt = word_nxt;
            end
            B3: begin
               cnt_nxt      = IDLE;
               asm_nxt      = '0;
               out_data_nxt = word_nxt;
               out32_nxt    = 1'b1;
            end
            default: cnt_nxt = IDLE;
         endcase
      end else if (cnt != IDLE) begin
         if (timeout) begin
            cnt_nxt  = IDLE;
            idle_nxt = '0;
            asm_nxt  = '0;
            err8_nxt = 1'b1;
         end else begin
            idle_nxt = idle_inc[GAP_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= IDLE;
         idle       <= '0;
         asm_r      <= '0;
         out_data32 <= '0;
         out32      <= 1'b0;
         err8       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         idle       <= idle_nxt;
         asm_r      <= asm_nxt;
         out_data32 <= out_data_nxt;
         out32      <= out32_nxt;
         err8       <= err8_nxt;
         busy       <= (cnt_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_conv8_32.sv
// Scoreboard bench for conv8_32: MSB-first and LSB-first instances share one
// byte stream and are checked against a byte-queue reference model.
module tb_conv8_32;

   localparam int GAP = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        in8;
   logic [7:0]  in_data8;
   logic [31:0] dm, dl;
   logic        o32m, o32l, em, el, bm, bl;

   conv8_32 #(.MSB_FIRST(1), .GAP_MAX(GAP), .GAP_W(4)) dut_m (
      .clk(clk), .reset(reset), .in_data8(in_data8), .in8(in8),
      .out_data32(dm), .out32(o32m), .err8(em), .busy(bm));

   conv8_32 #(.MSB_FIRST(0), .GAP_MAX(GAP), .GAP_W(4)) dut_l (
      .clk(clk), .reset(reset), .in_data8(in_data8), .in8(in8),
      .out_data32(dl), .out32(o32l), .err8(el), .busy(bl));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   logic [7:0]  bq[$];
   logic [31:0] exp_m_q[$], exp_l_q[$];
   int          idle_m;
   int          err_m_tok, err_l_tok;
   logic [31:0] last_m, last_l;
   logic        exp_busy;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   task automatic model_reset();
      bq.delete();
      exp_m_q.delete();
      exp_l_q.delete();
      idle_m    = 0;
      err_m_tok = 0;
      err_l_tok = 0;
      last_m    = '0;
      last_l    = '0;
      exp_busy  = 1'b0;
   endtask

   task automatic model_step(bit v, logic [7:0] d);
      logic [31:0] wm, wl;
      if (v) begin
         bq.push_back(d);
         idle_m = 0;
         if (bq.size() == 4) begin
            wm = '0;
            wl = '0;
            for (int i = 0; i < 4; i++) begin
               wm = wm * 256 + 32'(bq[i]);
               wl = wl + (32'(bq[i]) << (8 * i));
            end
            exp_m_q.push_back(wm);
            exp_l_q.push_back(wl);
            last_m = wm;
            last_l = wl;
            bq.delete();
         end
      end else if (bq.size() != 0) begin
         idle_m++;
         if (idle_m == GAP) begin
            bq.delete();
            idle_m = 0;
            err_m_tok++;
            err_l_tok++;
         end
      end
      exp_busy = (bq.size() != 0);
   endtask

   task automatic cyc(bit v, logic [7:0] d);
      in8      = v;
      in_data8 = v ? d : 8'($urandom);
      @(posedge clk);
      model_step(v, d);
      #1;
   endtask

   // monitor: pops expected words on each out32 pulse, checks held state every cycle
   always @(negedge clk) begin
      chk("busy_m", 32'(bm), 32'(exp_busy));
      chk("busy_l", 32'(bl), 32'(exp_busy));
      chk("hold_m", dm, last_m);
      chk("hold_l", dl, last_l);
      chk("excl_m", 32'(o32m & em), 32'd0);
      chk("excl_l", 32'(o32l & el), 32'd0);
      if (o32m) begin
         if (exp_m_q.size() == 0) chk("spurious_out32_m", 32'(o32m), 32'd0);
         else chk("word_m", dm, exp_m_q.pop_front());
      end
      if (o32l) begin
         if (exp_l_q.size() == 0) chk("spurious_out32_l", 32'(o32l), 32'd0);
         else chk("word_l", dl, exp_l_q.pop_front());
      end
      if (em) begin
         if (err_m_tok == 0) chk("spurious_err8_m", 32'(em), 32'd0);
         else err_m_tok--;
      end
      if (el) begin
         if (err_l_tok == 0) chk("spurious_err8_l", 32'(el), 32'd0);
         else err_l_tok--;
      end
      chk("missing_out32_m", 32'(exp_m_q.size()), 32'd0);
      chk("missing_out32_l", 32'(exp_l_q.size()), 32'd0);
      chk("missing_err8_m", 32'(err_m_tok), 32'd0);
      chk("missing_err8_l", 32'(err_l_tok), 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      reset    = 1'b0;
      in8      = 1'b0;
      in_data8 = 8'h00;
      model_reset();
      #1;
      chk("rst_data", dm, 32'd0);
      chk("rst_out32", 32'(o32m), 32'd0);
      chk("rst_err8", 32'(em), 32'd0);
      chk("rst_busy", 32'(bm), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // basic word, both byte orders
      cyc(1, 8'hAA); cyc(1, 8'hBB); cyc(1, 8'hCC); cyc(1, 8'hDD);
      chk("msb_word", dm, 32'hAABBCCDD);
      chk("lsb_word", dl, 32'hDDCCBBAA);
      chk("pulse_on", 32'(o32m), 32'd1);
      cyc(0, 8'h00);
      chk("pulse_off", 32'(o32m), 32'd0);

      // back-to-back stream
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 8'(i));
         if (i == 4) chk("b2b_first", dm, 32'h01020304);
         if (i == 8) chk("b2b_second", dm, 32'h05060708);
      end
      chk("b2b_lsb", dl, 32'h08070605);

      // gaps within a word
      cyc(1, 8'h11); cyc(0, 0); cyc(0, 0);
      cyc(1, 8'h22); cyc(0, 0); cyc(0, 0); cyc(0, 0);
      cyc(1, 8'h33); chk("gap_busy", 32'(bm), 32'd1);
      cyc(1, 8'h44);
      chk("gap_word", dm, 32'h11223344);
      chk("gap_busy_end", 32'(bm), 32'd0);

      // timeout discards the partial word
      cyc(1, 8'h55); cyc(1, 8'h66);
      repeat (GAP - 1) cyc(0, 0);
      chk("pre_timeout_err", 32'(em), 32'd0);
      cyc(0, 0);
      chk("timeout_err", 32'(em), 32'd1);
      chk("timeout_busy", 32'(bm), 32'd0);
      chk("timeout_hold", dm, 32'h11223344);
      cyc(1, 8'h01); cyc(1, 8'h02); cyc(1, 8'h03); cyc(1, 8'h04);
      chk("post_timeout_word", dm, 32'h01020304);

      // byte on the would-be timeout cycle is accepted
      cyc(1, 8'h55); cyc(1, 8'h66);
      repeat (GAP - 1) cyc(0, 0);
      cyc(1, 8'h77);
      chk("edge_no_err", 32'(em), 32'd0);
      chk("edge_busy", 32'(bm), 32'd1);
      cyc(1, 8'h88);
      chk("edge_word", dm, 32'h55667788);

      // asynchronous reset mid-word
      cyc(1, 8'hA1); cyc(1, 8'hA2);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_data", dm, 32'd0);
      chk("mid_rst_busy", 32'(bm), 32'd0);
      chk("mid_rst_err", 32'(em), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      cyc(1, 8'hC1); cyc(1, 8'hC2); cyc(1, 8'hC3); cyc(1, 8'hC4);
      chk("post_rst_word", dm, 32'hC1C2C3C4);

      // randomized traffic with varying density
      for (int blk = 0; blk < 12; blk++) begin
         case (blk % 3)
            0:       p = 90;
            1:       p = 50;
            default: p = 12;
         endcase
         for (int c = 0; c < 50; c++)
            cyc($urandom_range(0, 99) < p, 8'($urandom));
      end
      repeat (GAP + 4) cyc(0, 0);

      chk("end_queue_m", 32'(exp_m_q.size()), 32'd0);
      chk("end_queue_l", 32'(exp_l_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
